// File: rtl/bitwise_seq_unit_pkg.sv
// Shared types and constants for the bitwise sequencer: FSM state encoding
// and op_mask bit positions.
package bitwise_seq_unit_pkg;

    localparam int unsigned OPM_W   = 3;
    localparam int unsigned OPM_OR  = 0;
    localparam int unsigned OPM_AND = 1;
    localparam int unsigned OPM_XOR = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PH_OR  = 3'd1,
        S_PH_AND = 3'd2,
        S_PH_XOR = 3'd3,
        S_FIN    = 3'd4
    } state_e;

endpackage

// File: rtl/bitwise_step_timer.sv
// Loadable down-counter pacing result phases; zero_c flags that the next
// phase may fire.
module bitwise_step_timer #(
    parameter int unsigned STEP_CYCLES = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_zero,
    input  logic load_step,
    output logic zero_c
);

    localparam int unsigned CNT_W = $clog2(STEP_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // Reload wins over counting; the counter parks at zero instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load_zero) begin
            count <= '0;
        end else if (load_step) begin
            count <= CNT_W'(STEP_CYCLES - 1);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/bitwise_seq_unit.sv
// Cycle-paced bitwise OR/AND/XOR unit with operand handshake, per-result
// strobes and a per-request phase mask.
module bitwise_seq_unit
    import bitwise_seq_unit_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned STEP_CYCLES = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPM_W-1:0] op_mask,
    output logic [WIDTH-1:0] ab_or,
    output logic [WIDTH-1:0] ab_and,
    output logic [WIDTH-1:0] ab_xor,
    output logic             or_valid,
    output logic             and_valid,
    output logic             xor_valid,
    output logic             done,
    output logic             busy
);

    state_e           state;
    state_e           next_state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [OPM_W-1:0] mask_q;
    logic [OPM_W-1:0] pend;
    logic             accept;
    logic             fire_or;
    logic             fire_and;
    logic             fire_xor;
    logic             done_d;
    logic             tmr_load_zero;
    logic             tmr_load_step;
    logic             tmr_zero_c;

    bitwise_step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_zero(tmr_load_zero),
        .load_step(tmr_load_step),
        .zero_c   (tmr_zero_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Phases still owed from the current state onward; disabled ones are
    // skipped by jumping straight to the next pending phase.
    always_comb begin
        pend          = '0;
        accept        = 1'b0;
        fire_or       = 1'b0;
        fire_and      = 1'b0;
        fire_xor      = 1'b0;
        done_d        = 1'b0;
        tmr_load_zero = 1'b0;
        tmr_load_step = 1'b0;
        next_state    = state;

        pend[OPM_OR]  = mask_q[OPM_OR] && (state == S_PH_OR);
        pend[OPM_AND] = mask_q[OPM_AND] && (state == S_PH_OR || state == S_PH_AND);
        pend[OPM_XOR] = mask_q[OPM_XOR]
                        && (state == S_PH_OR || state == S_PH_AND || state == S_PH_XOR);

        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    accept        = 1'b1;
                    tmr_load_zero = 1'b1;
                    next_state    = S_PH_OR;
                end
            end
            S_PH_OR, S_PH_AND, S_PH_XOR: begin
                if (tmr_zero_c) begin
                    tmr_load_step = 1'b1;
                    if (pend[OPM_OR]) begin
                        fire_or = 1'b1;
                        if (pend[OPM_AND]) begin
                            next_state = S_PH_AND;
                        end else if (pend[OPM_XOR]) begin
                            next_state = S_PH_XOR;
                        end else begin
                            next_state = S_FIN;
                            done_d     = 1'b1;
                        end
                    end else if (pend[OPM_AND]) begin
                        fire_and = 1'b1;
                        if (pend[OPM_XOR]) begin
                            next_state = S_PH_XOR;
                        end else begin
                            next_state = S_FIN;
                            done_d     = 1'b1;
                        end
                    end else begin
                        fire_xor   = pend[OPM_XOR];
                        next_state = S_FIN;
                        done_d     = 1'b1;
                    end
                end
            end
            S_FIN: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            mask_q    <= '0;
            ab_or     <= '0;
            ab_and    <= '0;
            ab_xor    <= '0;
            or_valid  <= 1'b0;
            and_valid <= 1'b0;
            xor_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            or_valid  <= fire_or;
            and_valid <= fire_and;
            xor_valid <= fire_xor;
            done      <= done_d;
            busy      <= (next_state != S_IDLE);
            if (accept) begin
                a_q    <= a;
                b_q    <= b;
                mask_q <= op_mask;
            end
            if (fire_or) begin
                ab_or <= a_q | b_q;
            end
            if (fire_and) begin
                ab_and <= a_q & b_q;
            end
            if (fire_xor) begin
                ab_xor <= a_q ^ b_q;
            end
        end
    end

    assign in_ready = !busy;

endmodule

// File: tb/tb_bitwise_seq_unit.sv
// Directed bench for bitwise_seq_unit (WIDTH=8, STEP_CYCLES=5): vector table
// plus hand-written busy, back-to-back and mid-op reset sequences.
module tb_bitwise_seq_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op_mask;
    logic [7:0] ab_or;
    logic [7:0] ab_and;
    logic [7:0] ab_xor;
    logic       or_valid;
    logic       and_valid;
    logic       xor_valid;
    logic       done;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    bitwise_seq_unit #(
        .WIDTH      (8),
        .STEP_CYCLES(5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op_mask  (op_mask),
        .ab_or    (ab_or),
        .ab_and   (ab_and),
        .ab_xor   (ab_xor),
        .or_valid (or_valid),
        .and_valid(and_valid),
        .xor_valid(xor_valid),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] m;
        logic [7:0] x_or;
        logic [7:0] x_and;
        logic [7:0] x_xor;
        int         e_or;
        int         e_and;
        int         e_xor;
        int         e_done;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request accepted at edge 0; edges below are counted from it.
    task automatic run_req(input logic [7:0] ra, input logic [7:0] rb, input logic [2:0] rm,
                           output int e_or, output int e_and, output int e_xor,
                           output int e_done, output int e_ready, output int n_str);
        e_or = -1; e_and = -1; e_xor = -1; e_done = -1; e_ready = -1; n_str = 0;
        in_valid = 1'b1;
        a        = ra;
        b        = rb;
        op_mask  = rm;
        tick();
        in_valid = 1'b0;
        a        = ~ra;
        b        = ~rb;
        op_mask  = ~rm;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (or_valid)  begin n_str++; if (e_or  < 0) e_or  = e; end
            if (and_valid) begin n_str++; if (e_and < 0) e_and = e; end
            if (xor_valid) begin n_str++; if (e_xor < 0) e_xor = e; end
            if (done && e_done < 0) e_done = e;
            if (in_ready) begin
                e_ready = e;
                break;
            end
        end
    endtask

    initial begin
        int e_or, e_and, e_xor, e_done, e_ready, n_str;
        int n_or, n_and, n_xor, n_done;
        int first_ready, acc2, or2, and2, done2;
        logic prev_ready;

        vecs[0] = '{8'hC5, 8'h3A, 3'b111, 8'hFF, 8'h00, 8'hFF,  1,  6, 11, 11};
        vecs[1] = '{8'hF0, 8'h3C, 3'b101, 8'hFC, 8'h00, 8'hCC,  1, -1,  6,  6};
        vecs[2] = '{8'h0F, 8'hFF, 3'b000, 8'hFC, 8'h00, 8'hCC, -1, -1, -1,  1};
        vecs[3] = '{8'hAA, 8'h0F, 3'b010, 8'hFC, 8'h0A, 8'hCC, -1,  1, -1,  1};
        vecs[4] = '{8'h9C, 8'h36, 3'b110, 8'hFC, 8'h14, 8'hAA, -1,  1,  6,  6};
        vecs[5] = '{8'h12, 8'h34, 3'b011, 8'h36, 8'h10, 8'hAA,  1,  6, -1,  6};
        vecs[6] = '{8'h80, 8'h01, 3'b100, 8'h36, 8'h10, 8'h81, -1, -1,  1,  1};
        vecs[7] = '{8'hFF, 8'hFF, 3'b001, 8'hFF, 8'h10, 8'h81,  1, -1, -1,  1};

        // Reset state, with a request offered during reset.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 8'hAA;
        b        = 8'h55;
        op_mask  = 3'b111;
        tick();
        tick();
        chk("rst_or",    32'(ab_or),     32'h0);
        chk("rst_and",   32'(ab_and),    32'h0);
        chk("rst_xor",   32'(ab_xor),    32'h0);
        chk("rst_strb",  32'({or_valid, and_valid, xor_valid, done}), 32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_ready", 32'(in_ready),  32'h1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        n_str = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (or_valid || and_valid || xor_valid || done) n_str++;
        end
        chk("idle_no_strobe", 32'(n_str), 32'h0);

        // Request offered while busy is ignored.
        in_valid = 1'b1;
        a        = 8'hC5;
        b        = 8'h3A;
        op_mask  = 3'b111;
        tick();
        in_valid = 1'b0;
        a        = 8'h11;
        b        = 8'h11;
        n_or = 0; n_and = 0; n_xor = 0; n_done = 0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (or_valid)  n_or++;
            if (and_valid) n_and++;
            if (xor_valid) n_xor++;
            if (done)      n_done++;
            in_valid = (e >= 2 && e < 8);
        end
        chk("busy_rej_or",    32'(ab_or),  32'hFF);
        chk("busy_rej_and",   32'(ab_and), 32'h00);
        chk("busy_rej_xor",   32'(ab_xor), 32'hFF);
        chk("busy_rej_nstrb", 32'(n_or + n_and + n_xor), 32'd3);
        chk("busy_rej_ndone", 32'(n_done), 32'd1);

        // Table: one request per row, checking edges and final buses.
        for (int i = 0; i < 8; i++) begin
            run_req(vecs[i].a, vecs[i].b, vecs[i].m, e_or, e_and, e_xor, e_done, e_ready, n_str);
            chk($sformatf("v%0d_or_edge", i),    32'(e_or),    32'(vecs[i].e_or));
            chk($sformatf("v%0d_and_edge", i),   32'(e_and),   32'(vecs[i].e_and));
            chk($sformatf("v%0d_xor_edge", i),   32'(e_xor),   32'(vecs[i].e_xor));
            chk($sformatf("v%0d_done_edge", i),  32'(e_done),  32'(vecs[i].e_done));
            chk($sformatf("v%0d_ready_edge", i), 32'(e_ready), 32'(vecs[i].e_done + 1));
            chk($sformatf("v%0d_nstrb", i),      32'(n_str),   32'($countones(vecs[i].m)));
            chk($sformatf("v%0d_ab_or", i),      32'(ab_or),   32'(vecs[i].x_or));
            chk($sformatf("v%0d_ab_and", i),     32'(ab_and),  32'(vecs[i].x_and));
            chk($sformatf("v%0d_ab_xor", i),     32'(ab_xor),  32'(vecs[i].x_xor));
        end

        // Back-to-back: second request held on the bus from edge 0 onward.
        in_valid = 1'b1;
        a        = 8'hC5;
        b        = 8'h3A;
        op_mask  = 3'b111;
        tick();
        a          = 8'h12;
        b          = 8'h34;
        op_mask    = 3'b011;
        first_ready = -1; acc2 = -1; or2 = -1; and2 = -1; done2 = -1;
        prev_ready = in_ready;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (acc2 < 0 && prev_ready && in_valid) begin
                acc2     = e;
                in_valid = 1'b0;
                a        = 8'hEE;
                b        = 8'h77;
                op_mask  = 3'b111;
            end
            if (in_ready && first_ready < 0) first_ready = e;
            if (acc2 > 0 && or_valid  && or2  < 0) or2  = e;
            if (acc2 > 0 && and_valid && and2 < 0) and2 = e;
            if (acc2 > 0 && done      && done2 < 0) done2 = e;
            prev_ready = in_ready;
        end
        chk("b2b_ready_edge", 32'(first_ready), 32'd12);
        chk("b2b_accept2",    32'(acc2),        32'd13);
        chk("b2b_or2_edge",   32'(or2),         32'd14);
        chk("b2b_and2_edge",  32'(and2),        32'd19);
        chk("b2b_done2_edge", 32'(done2),       32'd19);
        chk("b2b_ab_or",      32'(ab_or),       32'h36);
        chk("b2b_ab_and",     32'(ab_and),      32'h10);
        chk("b2b_ab_xor",     32'(ab_xor),      32'hFF);

        // Mid-operation reset between edges 3 and 4 of a full sequence.
        in_valid = 1'b1;
        a        = 8'hC5;
        b        = 8'h3A;
        op_mask  = 3'b111;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_or",    32'(ab_or),    32'h0);
        chk("mrst_busy",  32'(busy),     32'h0);
        chk("mrst_ready", 32'(in_ready), 32'h1);
        tick();
        rst_n = 1'b1;
        n_str = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (or_valid || and_valid || xor_valid || done) n_str++;
        end
        chk("mrst_no_strobe", 32'(n_str), 32'h0);
        run_req(8'h5A, 8'h0F, 3'b111, e_or, e_and, e_xor, e_done, e_ready, n_str);
        chk("post_rst_edges", 32'({8'(e_or), 8'(e_and), 8'(e_xor), 8'(e_done)}),
            32'({8'd1, 8'd6, 8'd11, 8'd11}));
        chk("post_rst_or",  32'(ab_or),  32'h5F);
        chk("post_rst_and", 32'(ab_and), 32'h0A);
        chk("post_rst_xor", 32'(ab_xor), 32'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
